// File: rtl/tensor_core_pkg.sv
// tensor_core_pkg
// Shared definitions for the tensor core scheduler and the core's expose logic.
//   ELEM_W / DIM / MAT_W : 4-bit elements in a 4x4 matrix packed into 64 bits
//   sched_state_t        : scheduler FSM states
//   elem_offset()        : bit offset of element [row][col]; element [0][0]
//                          sits in the top nibble, row-major order
package tensor_core_pkg;

  localparam int unsigned ELEM_W = 4;
  localparam int unsigned DIM    = 4;
  localparam int unsigned MAT_W  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_RESP
  } sched_state_t;

  function automatic int unsigned elem_offset(input int unsigned row,
                                              input int unsigned col);
    return MAT_W - ELEM_W * (row * DIM + col + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
// Two-way round-robin arbiter with a registered last-grant pointer.
//   clock_in, reset_n_in : clock, synchronous active-low reset
//   req0_in, req1_in     : request lines
//   accept_in            : grant was consumed this cycle; advance the pointer
//   grant_out            : 0 selects requester 0, 1 selects requester 1
// With no request pending the grant rests on requester 0.
module rr_arbiter_2 (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic req0_in,
  input  logic req1_in,
  input  logic accept_in,
  output logic grant_out
);

  // Resets to 1 so requester 0 wins the first contested round.
  logic last_grant_q;

  always_comb begin
    grant_out = req1_in;
    if (req0_in && req1_in) begin
      grant_out = ~last_grant_q;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      last_grant_q <= 1'b1;
    end else if (accept_in) begin
      last_grant_q <= grant_out;
    end
  end

endmodule

// File: rtl/tensor_core_scheduler.sv
// tensor_core_scheduler
// Accepts 4x4 MMA jobs from two requesters, arbitrates round-robin, loads the
// single tensor core, times the compute and returns the tagged result.
// Ports:
//   clock_in, reset_n_in          : clock, synchronous active-low reset
//   reqN_valid/ready, reqN_a/b    : job request channels (N = 0, 1)
//   result_valid/ready/id/data    : shared result channel
//   result_error_out              : watchdog abort flag (0 unless macro build)
//   core_write_enable_out         : one-cycle load strobe to the core
//   core_input1_out/2_out         : operands, held from LOAD to end of RESP
//   core_output_in, core_done_in  : core result and completion flag
//   busy_out                      : high whenever not IDLE
// Build option: TENSOR_CORE_SCHEDULER_DONE_WAIT_EN exits COMPUTE on the core's
// done flag with a WATCHDOG_CYCLES timeout instead of a fixed cycle count.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both high; ready never depends on anything but state
// and arbitration, and a producer holds its payload stable while valid is
// high and no transfer has happened.
module tensor_core_scheduler
  import tensor_core_pkg::*;
#(
  parameter int unsigned COMPUTE_CYCLES  = 16,
  parameter int unsigned WATCHDOG_CYCLES = 32
) (
  input  logic              clock_in,
  input  logic              reset_n_in,
  input  logic              req0_valid_in,
  output logic              req0_ready_out,
  input  logic [MAT_W-1:0]  req0_a_in,
  input  logic [MAT_W-1:0]  req0_b_in,
  input  logic              req1_valid_in,
  output logic              req1_ready_out,
  input  logic [MAT_W-1:0]  req1_a_in,
  input  logic [MAT_W-1:0]  req1_b_in,
  output logic              result_valid_out,
  input  logic              result_ready_in,
  output logic              result_id_out,
  output logic [MAT_W-1:0]  result_data_out,
  output logic              result_error_out,
  output logic              core_write_enable_out,
  output logic [MAT_W-1:0]  core_input1_out,
  output logic [MAT_W-1:0]  core_input2_out,
  input  logic [MAT_W-1:0]  core_output_in,
  input  logic              core_done_in,
  output logic              busy_out
);

  sched_state_t     state_q, state_d;
  logic [15:0]      cnt_q;
  logic [MAT_W-1:0] op_a_q, op_b_q, res_data_q;
  logic             op_id_q, res_id_q;
  logic             grant, accept, capture;

  // Keeps the parameter relationship and the done input referenced in
  // every build variant.
  logic unused_ok;
  assign unused_ok = core_done_in & (WATCHDOG_CYCLES > COMPUTE_CYCLES);

  rr_arbiter_2 u_arb (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .req0_in    (req0_valid_in),
    .req1_in    (req1_valid_in),
    .accept_in  (accept),
    .grant_out  (grant)
  );

  // Gated by reset so no request is accepted while reset is asserted.
  assign req0_ready_out = reset_n_in && (state_q == ST_IDLE) && !grant;
  assign req1_ready_out = reset_n_in && (state_q == ST_IDLE) && grant;
  assign accept = (req0_valid_in && req0_ready_out) ||
                  (req1_valid_in && req1_ready_out);

`ifdef TENSOR_CORE_SCHEDULER_DONE_WAIT_EN
  localparam logic [15:0] WD_CNT = 16'(WATCHDOG_CYCLES - 1);
  logic capture_err;
  logic res_err_q;
  assign result_error_out = res_err_q;
`else
  localparam logic [15:0] LAST_CNT = 16'(COMPUTE_CYCLES - 1);
  assign result_error_out = 1'b0;
`endif

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    capture               = 1'b0;
    core_write_enable_out = 1'b0;
    result_valid_out      = 1'b0;
`ifdef TENSOR_CORE_SCHEDULER_DONE_WAIT_EN
    capture_err           = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        core_write_enable_out = 1'b1;
        state_d               = ST_COMPUTE;
      end
      ST_COMPUTE: begin
`ifdef TENSOR_CORE_SCHEDULER_DONE_WAIT_EN
        // Counter 0 is the first cycle after the load strobe; a done seen
        // there is stale from the previous job.
        if (core_done_in && (cnt_q != 16'd0)) begin
          capture = 1'b1;
        end else if (cnt_q == WD_CNT) begin
          capture     = 1'b1;
          capture_err = 1'b1;
        end
`else
        if (cnt_q == LAST_CNT) capture = 1'b1;
`endif
        if (capture) state_d = ST_RESP;
      end
      ST_RESP: begin
        result_valid_out = 1'b1;
        if (result_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n_in) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_id_q    <= 1'b0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      cnt_q      <= '0;
`ifdef TENSOR_CORE_SCHEDULER_DONE_WAIT_EN
      res_err_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_a_q  <= grant ? req1_a_in : req0_a_in;
        op_b_q  <= grant ? req1_b_in : req0_b_in;
        op_id_q <= grant;
      end
      if (state_q == ST_LOAD) begin
        cnt_q <= '0;
      end else if (state_q == ST_COMPUTE) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (capture) begin
        res_data_q <= core_output_in;
        res_id_q   <= op_id_q;
`ifdef TENSOR_CORE_SCHEDULER_DONE_WAIT_EN
        res_err_q  <= capture_err;
`endif
      end
    end
  end

  assign core_input1_out = op_a_q;
  assign core_input2_out = op_b_q;
  assign result_data_out = res_data_q;
  assign result_id_out   = res_id_q;
  assign busy_out        = (state_q != ST_IDLE);

endmodule

// File: doc/tensor_core_scheduler.md
# tensor_core_scheduler

Sequencing and arbitration controller for `small_tensor_core_mma`. It accepts 4x4 matrix-multiply jobs from two requesters over valid/ready handshakes and arbitrates between them round-robin. It latches the operands, pulses the core's load strobe and times the serial 16-element compute. It then captures the 64-bit result and returns it on a shared result channel tagged with the requester ID. It sits between the register-file/issue logic and the single tensor core instance, so no requester drives the core directly.

## Interface
Parameters:
- `COMPUTE_CYCLES`, 16: core cycles per job (one output element per cycle); legal range 1..255.
- `WATCHDOG_CYCLES`, 32: done-wait limit, used only with the configuration macro; must be > `COMPUTE_CYCLES`.

Ports:
- `clock_in`  in  1  single clock, all logic on posedge.
- `reset_n_in`  in  1  synchronous, active-low reset.
- `req0_valid_in` / `req1_valid_in`  in  1  job request per requester.
- `req0_ready_out` / `req1_ready_out`  out  1  job accepted this cycle when valid & ready.
- `req0_a_in`, `req0_b_in`, `req1_a_in`, `req1_b_in`  in  64  operand matrices, 16 x 4-bit, element [0][0] in bits [63:60], row-major.
- `result_valid_out`  out  1  result available.
- `result_ready_in`  in  1  result consumer ready.
- `result_id_out`  out  1  requester that owns the result.
- `result_data_out`  out  64  product matrix, same packing as operands, elements mod 16.
- `result_error_out`  out  1  watchdog abort flag (macro builds only; otherwise constant 0).
- `core_write_enable_out`  out  1  to core `tensor_core_register_file_write_enable`.
- `core_input1_out`, `core_input2_out`  out  64  to core operand inputs.
- `core_output_in`  in  64  from core `tensor_core_output`.
- `core_done_in`  in  1  from core `is_done_with_calculation`.
- `busy_out`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, LOAD, COMPUTE, RESP.
- IDLE: `reqN_ready_out` = (state==IDLE) & grant==N. This is combinational from the registered state and the arbiter grant.
  - Arbiter: if only one requester is valid, it is granted.
  - If both are valid, grant the one not served last. `last_grant` resets to 1, so requester 0 wins first.
  - On accept: latch A, B and ID into operand registers, update `last_grant`, go to LOAD.
- LOAD (1 cycle): `core_write_enable_out`=1. Go to COMPUTE and clear the cycle counter.
- COMPUTE: `core_write_enable_out`=0. The counter increments each cycle.
  - On the cycle with counter==`COMPUTE_CYCLES`-1, capture `core_output_in` into `result_data_out` and go to RESP.
- RESP: `result_valid_out`=1 until `result_ready_in`=1, then go to IDLE. Result data, ID and error are held stable while valid.
- Core inputs are driven from the operand registers in every state. They never change between LOAD and the end of RESP.
- Requesters must hold operands stable while valid and not yet accepted. A requester deasserting valid before acceptance withdraws its request.
- Mid-operation reset: next cycle is IDLE and the pending result is discarded. The core is not reset here; the next LOAD reinitialises it.

## Timing
- Reset values:
  - state IDLE; all ready outputs 0 during reset; `result_valid_out` 0; `result_data_out` 0; `result_id_out` 0; `result_error_out` 0.
  - `core_write_enable_out` 0; core inputs 0; `busy_out` 0; `last_grant` 1.
- Accept in cycle 0 leads to LOAD in cycle 1 and COMPUTE in cycles 2..`COMPUTE_CYCLES`+1.
  - `result_valid_out` rises in cycle `COMPUTE_CYCLES`+2, i.e. 18 with defaults.
- A result handshake in cycle R gives IDLE in R+1, with the earliest next accept in R+1.
  - Minimum job pitch is `COMPUTE_CYCLES`+3.
- Simultaneous valid on both requesters at reset release: requester 0 in the first job, requester 1 in the next.
- `result_ready_in` high before `result_valid_out` has no effect. A single-cycle valid+ready completes the transfer.

## Configuration
- `TENSOR_CORE_SCHEDULER_DONE_WAIT_EN`
- Undefined: COMPUTE exit is purely count-based as above. `core_done_in` is ignored and `result_error_out` is tied 0.
- Defined:
  - COMPUTE exits at the first cycle with `core_done_in`=1 and counter ≥ 1. Data is captured at that edge, with error 0.
  - If the counter reaches `WATCHDOG_CYCLES`-1 without done, capture `core_output_in` anyway and set `result_error_out`=1 for that result.

## Structure
- Shared package `tensor_core_pkg`:
  - `ELEM_W`=4, `DIM`=4, `MAT_W`=64.
  - The state enum.
  - An element index-to-bit-offset function, shared with the core's expose logic.
- Sub-module `rr_arbiter_2`: two requests, registered `last_grant`, and an update-on-accept input.

## Test plan
- Reset, then A=64'h1000_0100_0010_0001 (identity) and B=64'h2222_2222_2222_2222 on req0 → accept in cycle 0, LOAD write-enable pulse in cycle 1, `result_valid_out` in cycle 18 with data 64'h2222_2222_2222_2222 and ID 0.
- Both requesters valid at once (req1 A=identity, B=64'h0123_4567_89AB_CDEF) → req0 served first, then req1 result equal to B with ID 1. Pitch is 19 cycles with `result_ready_in` held high.
- `result_ready_in` held low for 10 cycles in RESP → valid, data and ID stable; no new accept; `busy_out`=1.
- Overflow: A=B=all 4'hF → each element (4·225) mod 16 = 4'h4, giving 64'h4444_4444_4444_4444.
- `reset_n_in` low in cycle 8 of COMPUTE → IDLE next cycle, no result. A following job completes correctly.
- Macro build with `core_done_in` forced 0 → result in cycle 34 with `result_error_out`=1. With done asserted at counter 15, the result has error 0.
